// File: rtl/dadda_cpa_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dadda_cpa_pipe
// Description : Final carry-propagate adder of the Dadda multiplier. Adds the
//               sum row and carry row left by the reduction tree. The carry
//               chain is cut into SEG-bit segments, one segment per pipeline
//               stage, with a bubble-collapsing valid/ready handshake.
// Ports       : clk       - clock, all state on the rising edge
//               rst       - synchronous active-high reset
//               in_valid  - row_a/row_b valid this cycle
//               in_ready  - pipe accepts an input this cycle
//               row_a     - sum row from the reduction tree
//               row_b     - carry row from the reduction tree
//               out_valid - product/cout valid
//               out_ready - downstream accepts the product this cycle
//               product   - (row_a + row_b) mod 2^WIDTH
//               cout      - carry out of bit WIDTH-1
// Revision    : 1.0 - initial release
// ============================================================================
module dadda_cpa_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_a,
    input  logic [WIDTH-1:0] row_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             cout
);

    localparam int STAGES = WIDTH / SEG;

    generate
        if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_param_check
            $error("dadda_cpa_pipe: WIDTH must be a non-zero multiple of SEG");
        end
    endgenerate

    // Per-stage state. Stage k holds the sum bits of segments 0..k, the carry
    // into segment k+1 and the still-unprocessed upper bits of both rows.
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];

    // Stage inputs (previous stage or the ports) and next-state values.
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_src_valid;
    logic [STAGES-1:0] w_src_cin;
    logic [STAGES-1:0] w_nxt_carry;
    logic [WIDTH-1:0]  w_src_sum [STAGES];
    logic [WIDTH-1:0]  w_src_a   [STAGES];
    logic [WIDTH-1:0]  w_src_b   [STAGES];
    logic [WIDTH-1:0]  w_nxt_sum [STAGES];
    logic [SEG:0]      w_seg     [STAGES];

    // Load enables. A stage may load when the downstream consumer takes the
    // product or when it, or any stage after it, holds a bubble. Expressing
    // this directly over the valid bits avoids a combinational chain through
    // w_load itself and keeps in_ready independent of in_valid.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_load[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!r_valid[j]) begin
                    w_load[k] = 1'b1;
                end
            end
        end
    end

    // Segment adders: stage k adds segment k of its operands plus the carry
    // handed over by stage k-1 (stage 0 starts with carry-in 0).
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                w_src_valid[k] = in_valid;
                w_src_cin[k]   = 1'b0;
                w_src_sum[k]   = '0;
                w_src_a[k]     = row_a;
                w_src_b[k]     = row_b;
            end else begin
                w_src_valid[k] = r_valid[k-1];
                w_src_cin[k]   = r_carry[k-1];
                w_src_sum[k]   = r_sum[k-1];
                w_src_a[k]     = r_a[k-1];
                w_src_b[k]     = r_b[k-1];
            end

            w_seg[k] = {1'b0, w_src_a[k][k*SEG +: SEG]}
                     + {1'b0, w_src_b[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_src_cin[k]};

            w_nxt_sum[k]                = w_src_sum[k];
            w_nxt_sum[k][k*SEG +: SEG]  = w_seg[k][SEG-1:0];
            w_nxt_carry[k]              = w_seg[k][SEG];
        end
    end

    // Pipeline registers. Data only updates when a valid entry moves in, so
    // the output registers keep the last product while a bubble passes.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rst) begin
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
            end else if (w_load[k]) begin
                r_valid[k] <= w_src_valid[k];
                if (w_src_valid[k]) begin
                    r_carry[k] <= w_nxt_carry[k];
                    r_sum[k]   <= w_nxt_sum[k];
                    r_a[k]     <= w_src_a[k];
                    r_b[k]     <= w_src_b[k];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[STAGES-1];
    assign product   = r_sum[STAGES-1];
    assign cout      = r_carry[STAGES-1];

endmodule
`default_nettype wire
